// File: rtl/mem_stage.sv
// Memory stage of the 5-stage RV32I pipeline: EX/MEM register, one aligned data-memory
// request per instruction, stall until response, load formatting and writeback payload.

package rv32i_types;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] wb_sel;
  } wb_ctrl_t;

  typedef struct packed {
    logic        valid_s;
    logic [31:0] inst_s;
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [63:0] order_s;
    mem_ctrl_t   mem_ctrl_s;
    wb_ctrl_t    wb_ctrl_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v_s;
    logic [31:0] rs2_v_s;
    logic [31:0] alu_out_s;
    logic        br_en_s;
    logic [31:0] u_imm_s;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic        valid_s;
    logic [31:0] inst_s;
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [63:0] order_s;
    wb_ctrl_t    wb_ctrl_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v_s;
    logic [31:0] rs2_v_s;
    logic [31:0] alu_out_s;
    logic        br_en_s;
    logic [31:0] u_imm_s;
    logic [31:0] load_data_s;
    logic [31:0] mem_addr_s;
    logic [3:0]  mem_rmask_s;
    logic [3:0]  mem_wmask_s;
    logic [31:0] mem_rdata_s;
    logic [31:0] mem_wdata_s;
  } mem_wb_stage_reg_t;

endpackage

module mem_stage
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  ex_mem_stage_reg_t ex_mem_reg,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              mem_stall,
  output mem_wb_stage_reg_t mem_wb_reg
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  ex_mem_stage_reg_t em_q;
  state_e            state_q, state_d;
  logic              issued_q, issued_d;
  logic [3:0]        rmask_q, rmask_d;  // masks actually issued, reported to RVFI
  logic [3:0]        wmask_q, wmask_d;

  logic [1:0]  off;
  logic [2:0]  funct3;
  logic        is_read, is_write;
  logic [3:0]  lane_mask;
  logic        aligned;
  logic        mem_op;
  logic [31:0] wdata;
  logic [31:0] lane;
  logic [31:0] load_fmt;
  logic [31:0] load_data;

  assign off      = em_q.alu_out_s[1:0];
  assign funct3   = em_q.mem_ctrl_s.funct3;
  assign is_read  = em_q.mem_ctrl_s.mem_read;
  assign is_write = em_q.mem_ctrl_s.mem_write;
  assign wdata    = em_q.rs2_v_s << {off, 3'b000};
  assign lane     = dmem_rdata >> {off, 3'b000};

  assign dmem_addr  = {em_q.alu_out_s[31:2], 2'b00};
  assign dmem_wdata = wdata;

  // Byte-lane mask and alignment check from access size and address offset
  always_comb begin
    lane_mask = 4'b0000;
    aligned   = 1'b0;
    unique case (funct3[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << off;
        aligned   = 1'b1;
      end
      2'b01: begin
        lane_mask = 4'b0011 << off;
        aligned   = (off != 2'd3);
      end
      2'b10: begin
        lane_mask = 4'b1111;
        aligned   = (off == 2'd0);
      end
      default: begin
        lane_mask = 4'b0000;
        aligned   = 1'b0;
      end
    endcase
  end

  assign mem_op = em_q.valid_s && (is_read || is_write) && aligned;

  // Request FSM: issue once from idle, then stall until the response pulse
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    rmask_d    = rmask_q;
    wmask_d    = wmask_q;
    dmem_rmask = 4'b0000;
    dmem_wmask = 4'b0000;
    mem_stall  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op && !issued_q) begin
          dmem_rmask = is_read ? lane_mask : 4'b0000;
          dmem_wmask = is_write ? lane_mask : 4'b0000;
          mem_stall  = 1'b1;
          issued_d   = 1'b1;
          rmask_d    = is_read ? lane_mask : 4'b0000;
          wmask_d    = is_write ? lane_mask : 4'b0000;
          state_d    = StWait;
        end
      end
      StWait: begin
        mem_stall = !dmem_resp;
        if (dmem_resp) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage register, FSM state and issue bookkeeping; a new entry clears the issue record
  always_ff @(posedge clk) begin
    if (rst) begin
      em_q     <= '0;
      state_q  <= StIdle;
      issued_q <= 1'b0;
      rmask_q  <= 4'b0000;
      wmask_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (!mem_stall) begin
        em_q     <= ex_mem_reg;
        issued_q <= 1'b0;
        rmask_q  <= 4'b0000;
        wmask_q  <= 4'b0000;
      end else begin
        issued_q <= issued_d;
        rmask_q  <= rmask_d;
        wmask_q  <= wmask_d;
      end
    end
  end

  // Select and extend the addressed lane of the returned word
  always_comb begin
    load_fmt = 32'h0;
    unique case (funct3)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b010:  load_fmt = dmem_rdata;
      3'b100:  load_fmt = {24'h0, lane[7:0]};
      3'b101:  load_fmt = {16'h0, lane[15:0]};
      default: load_fmt = 32'h0;
    endcase
  end

  // Misaligned loads never touch memory and retire with zero
  assign load_data = (is_read && aligned) ? load_fmt : 32'h0;

  // Writeback payload; bubble while the access is outstanding
  always_comb begin
    mem_wb_reg             = '0;
    mem_wb_reg.valid_s     = em_q.valid_s && !mem_stall;
    mem_wb_reg.inst_s      = em_q.inst_s;
    mem_wb_reg.pc_s        = em_q.pc_s;
    mem_wb_reg.pc_next_s   = em_q.pc_next_s;
    mem_wb_reg.order_s     = em_q.order_s;
    mem_wb_reg.wb_ctrl_s   = em_q.wb_ctrl_s;
    mem_wb_reg.rd_s        = em_q.rd_s;
    mem_wb_reg.rs1_s       = em_q.rs1_s;
    mem_wb_reg.rs2_s       = em_q.rs2_s;
    mem_wb_reg.rs1_v_s     = em_q.rs1_v_s;
    mem_wb_reg.rs2_v_s     = em_q.rs2_v_s;
    mem_wb_reg.alu_out_s   = em_q.alu_out_s;
    mem_wb_reg.br_en_s     = em_q.br_en_s;
    mem_wb_reg.u_imm_s     = em_q.u_imm_s;
    mem_wb_reg.load_data_s = load_data;
    mem_wb_reg.mem_addr_s  = dmem_addr;
    mem_wb_reg.mem_rmask_s = rmask_q;
    mem_wb_reg.mem_wmask_s = wmask_q;
    mem_wb_reg.mem_rdata_s = (rmask_q != 4'b0000) ? dmem_rdata : 32'h0;
    mem_wb_reg.mem_wdata_s = (wmask_q != 4'b0000) ? wdata : 32'h0;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline. Sits directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and issues aligned data-memory requests for loads and stores.
- Stalls the pipeline until the data memory responds, then formats load data.
- Drives a mem_wb_stage_reg_t to the writeback stage.

Parameters:
- none (XLEN fixed at 32; all types come from rv32i_types)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_mem_reg  in  ex_mem_stage_reg_t  execute-stage output (alu_out_s = effective address, rs2_v_s = store data)
- dmem_addr  out  32  word-aligned address, {ea[31:2],2'b00}
- dmem_rmask  out  4  byte read mask; nonzero only in the request cycle
- dmem_wmask  out  4  byte write mask; nonzero only in the request cycle
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  read data, valid with dmem_resp
- dmem_resp  in  1  one-cycle response pulse
- mem_stall  out  1  high while a memory access is outstanding; freezes IF/ID/EX and this stage's register
- mem_wb_reg  out  mem_wb_stage_reg_t  payload for writeback (combinational from internal state)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - stage register valid = 0; FSM = IDLE.
  - dmem_rmask = dmem_wmask = 0; mem_stall = 0; mem_wb_reg.valid_s = 0.
- Stage register:
  - On each clk edge with mem_stall = 0, load ex_mem_reg; otherwise hold.
  - rst has priority over the load.
- Control fields used: mem_ctrl_s.mem_read, mem_ctrl_s.mem_write, mem_ctrl_s.funct3.
- Memory op definition: register valid and (mem_read or mem_write) and address aligned.
- FSM, two states:
  - IDLE:
    - If the register holds a memory op that has not yet been issued, drive the request this cycle (masks/addr/wdata), assert mem_stall, and go to WAIT.
    - Otherwise masks = 0, mem_stall = 0.
  - WAIT:
    - Masks = 0.
    - mem_stall = !dmem_resp.
    - On dmem_resp, go to IDLE. The same edge loads the next instruction, so no re-issue occurs.
- Issue flag: the request is issued exactly once per stage-register occupancy. Cleared when a new entry is loaded.
- Response latency: at least 1 cycle after the request. A memory op therefore stalls for at least 1 cycle; non-memory ops never stall.
- Masks (off = ea[1:0]):
  - byte: 4'b0001 << off
  - half: 4'b0011 << off
  - word: 4'b1111
- Store data: dmem_wdata = rs2_v << (8*off).
- Misalignment:
  - half with off = 3, or word with off != 0: no request, no stall, masks 0.
  - Load result 0; instruction still retires (valid_s passes through).
- Load format (funct3):
  - LB / LH: sign-extend the selected lane.
  - LBU / LHU: zero-extend.
  - LW: full word.
  - Uses dmem_rdata in the response cycle.
- mem_wb_reg:
  - Passes through inst, pc, pc_next, order, wb_ctrl, rd_s, rs1_s, rs2_s, rs1_v, rs2_v, alu_out, br_en and u_imm.
  - Adds load_data and RVFI fields: mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata. The masks are the values issued, not the current port values.
  - valid_s = register valid && !mem_stall. Bubbles are emitted while stalled.
- Stray response: dmem_resp in IDLE is ignored; no state change.
- Reset during WAIT: FSM returns to IDLE and the register is invalidated. A late dmem_resp afterwards is ignored.
- Invalid entry: no request and no stall, regardless of control bits.

Test Plan:
- ALU op (mem_read = mem_write = 0, alu_out = 0x1234) -> no request, mem_stall = 0, mem_wb_reg.alu_out_s = 0x1234, valid_s = 1 on the next cycle.
- LB, ea = 0x1003, resp 2 cycles later with rdata = 0x80FF_FF00:
  - dmem_addr = 0x1000, rmask = 4'b1000 for exactly 1 cycle.
  - mem_stall high 2 cycles.
  - load_data = 0xFFFF_FF80.
  - LBU variant gives 0x0000_0080.
- SH, ea = 0x2002, rs2_v = 0xDEAD_BEEF -> wmask = 4'b1100, wdata = 0xBEEF_0000 for 1 cycle, stall until resp, RVFI wmask = 4'b1100.
- Back-to-back LW 0x10 then SW 0x14, each resp at latency 1 -> exactly two requests, no duplicate issue, loads retire in order with consecutive order_s.
- LW at ea = 0x3001 (misaligned) -> masks 0, no stall, load_data = 0, valid_s = 1.
- rst asserted in WAIT, then dmem_resp pulse -> FSM IDLE, valid_s = 0, no request issued, mem_stall = 0.
